fetch_pc_unit: RTL
==================

Name: fetch_pc_unit

Overview:
- Program-counter and fetch-control stage directly upstream of the ALU. It generates the instruction-memory address each cycle.
- Consumes the ALU's SEQ/SNE result (Out[0], i.e. Odd) to resolve conditional branches. Targets come from a small writable branch-target LUT.
- Provides start/halt sequencing and run-cycle accounting for the top-level testbench.

Parameters:
- PCW, 10, program-counter width in bits
- LUTD, 16, branch-target LUT depth; index width is $clog2(LUTD)
- CNTW, 16, run-cycle counter width
- START_PC, 0, PC value loaded on Start

Ports:
- Clk  input  1  system clock, rising edge
- Reset  input  1  asynchronous, active-low reset
- Start  input  1  level request to begin execution from START_PC
- Halt  input  1  decoded halt instruction in current cycle
- BranchEn  input  1  decoded conditional-branch instruction in current cycle
- BranchCond  input  1  ALU Odd flag (Out[0] of SEQ/SNE); branch taken when 1
- TargetIdx  input  $clog2(LUTD)  LUT index from the branch instruction
- LutWe  input  1  LUT write enable
- LutWaddr  input  $clog2(LUTD)  LUT write index
- LutWdata  input  PCW  LUT write data
- PC  output  PCW  current instruction address
- Busy  output  1  high while in RUN
- Done  output  1  high while in HALTED
- Wrapped  output  1  sticky: PC wrapped from all-ones to 0 during this run
- CycleCnt  output  CNTW  number of RUN cycles this run, saturating

Behaviour:
- Reset (async, Reset=0) sets PC=0, state=IDLE, Busy=0, Done=0, Wrapped=0, CycleCnt=0, and all LUT entries=0. Reset asserted mid-RUN aborts immediately with the same values.
- State machine IDLE/RUN/HALTED, encoded as a typedef enum. Busy = (state==RUN). Done = (state==HALTED). Both are registered-state decodes with no extra latency.
- IDLE:
  - Start=1 at a clock edge loads PC<=START_PC, clears CycleCnt and Wrapped, and moves to RUN.
  - Halt, BranchEn and BranchCond are ignored in IDLE.
- RUN, per rising edge, first match wins:
  - 1. Halt=1: go to HALTED; PC holds.
  - 2. BranchEn=1 and BranchCond=1: PC <= LUT[TargetIdx].
  - 3. Otherwise (including BranchEn=1 with BranchCond=0): PC <= PC+1, modulo 2^PCW. If PC was all-ones, set Wrapped=1.
  - CycleCnt increments every RUN cycle, including the halting cycle, and saturates at all-ones.
  - Start is ignored while in RUN.
- HALTED:
  - PC, CycleCnt and Wrapped hold.
  - Start=0 at an edge returns to IDLE.
  - Start held at 1 keeps the unit in HALTED. A new run therefore requires Start to deassert and then reassert.
- Branch timing: PC presented in cycle N reflects the decisions made at edge N. Instruction memory and decode are combinational from PC, so a branch adds no bubble.
- LUT write:
  - Synchronous on the rising edge when LutWe=1, and allowed in any state.
  - Same-edge write and taken branch to the same index: the branch uses the old entry and the new value is visible from the next edge.
  - TargetIdx values at or above LUTD (non-power-of-2 depth) read 0.

Optional Feature:
- Macro: PC_REL_BRANCH_EN.
- Defined: a taken branch computes PC <= PC + LUT[TargetIdx], with the entry treated as a signed two's-complement PCW-bit offset and wrapping modulo 2^PCW. Wrap through a branch does not set Wrapped.
- Undefined: branch targets are absolute (PC <= LUT[TargetIdx]).
- Port list is identical in both builds.

Decomposition:
- Shared package Definitions holds:
  - typedef enum logic[1:0] fetch_state_t {IDLE, RUN, HALTED}
  - localparam defaults for PCW and LUTD
- One sub-module, branch_lut: LUTD x PCW register array with async-reset clear, one synchronous write port and one combinational read port.
- fetch_pc_unit instantiates branch_lut and holds the FSM, PC register and counters.

Test Plan:
- Reset then Start=1 for one cycle, with no branches and Halt asserted when PC==5 → PC sequence 0,1,2,3,4,5; Done=1; CycleCnt=6; Busy=0.
- Write LUT[3]=0x040. In RUN at PC=2, drive BranchEn=1, BranchCond=1, TargetIdx=3 → next PC=0x040. Repeat with BranchCond=0 → next PC=3.
- Halt=1 and BranchEn=1/BranchCond=1 on the same cycle → HALTED and PC unchanged. Hold Start=1 → stays HALTED. Drop Start → IDLE. Reassert → PC=0, CycleCnt cleared.
- PCW=4, run without halting → PC goes 15→0 and Wrapped=1. CycleCnt keeps counting; with CNTW=3 it saturates at 7.
- Same-edge LutWe to LUT[2]=0x055 and a taken branch via index 2, old value 0x011 → PC=0x011. A later branch via index 2 → PC=0x055.
- Reset pulsed low mid-RUN at PC=0x020 → PC=0, IDLE, LUT cleared immediately without waiting for a clock. With PC_REL_BRANCH_EN, LUT[1]=0x3FE (-2) at PC=0x010 taken → PC=0x00E.

Source files
------------

// File: rtl/fetch_pc_unit_pkg.sv
// Shared types and default sizes for the fetch/PC stage.
package fetch_pc_unit_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam int DEF_PCW  = 10;
  localparam int DEF_LUTD = 16;
  localparam int DEF_CNTW = 16;

endpackage

// File: rtl/fetch_pc_unit_branch_lut.sv
// Branch-target LUT: LUTD x PCW registers, async clear, one sync write port,
// one combinational read port. Indices at or above LUTD read as zero.
module branch_lut
  import fetch_pc_unit_pkg::*;
#(
  parameter int PCW  = DEF_PCW,
  parameter int LUTD = DEF_LUTD,
  parameter int IW   = $clog2(LUTD)
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           i_we,
  input  logic [IW-1:0]  i_waddr,
  input  logic [PCW-1:0] i_wdata,
  input  logic [IW-1:0]  i_raddr,
  output logic [PCW-1:0] o_rdata
);

  logic [PCW-1:0] r_mem [LUTD];

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < LUTD; i++) r_mem[i] <= '0;
    end else if (i_we && (32'(i_waddr) < LUTD)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read is pre-edge, so a same-edge write is only seen from the next cycle.
  assign o_rdata = (32'(i_raddr) < LUTD) ? r_mem[i_raddr] : '0;

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter, fetch FSM and run-cycle accounting upstream of the ALU.
// Build option: define PC_REL_BRANCH_EN for PC-relative (signed offset) branches.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter int             PCW      = DEF_PCW,
  parameter int             LUTD     = DEF_LUTD,
  parameter int             CNTW     = DEF_CNTW,
  parameter logic [PCW-1:0] START_PC = '0,
  parameter int             IW       = $clog2(LUTD)
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic            Halt,
  input  logic            BranchEn,
  input  logic            BranchCond,
  input  logic [IW-1:0]   TargetIdx,
  input  logic            LutWe,
  input  logic [IW-1:0]   LutWaddr,
  input  logic [PCW-1:0]  LutWdata,
  output logic [PCW-1:0]  PC,
  output logic            Busy,
  output logic            Done,
  output logic            Wrapped,
  output logic [CNTW-1:0] CycleCnt
);

  fetch_state_t    r_state;
  fetch_state_t    w_next_state;
  logic [PCW-1:0]  r_pc;
  logic [CNTW-1:0] r_cnt;
  logic            r_wrapped;
  logic [PCW-1:0]  w_lut_rdata;
  logic [PCW-1:0]  w_target;
  logic            w_taken;

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  branch_lut #(
    .PCW  (PCW),
    .LUTD (LUTD),
    .IW   (IW)
  ) u_lut (
    .Clk     (Clk),
    .Reset   (Reset),
    .i_we    (LutWe),
    .i_waddr (LutWaddr),
    .i_wdata (LutWdata),
    .i_raddr (TargetIdx),
    .o_rdata (w_lut_rdata)
  );

`ifdef PC_REL_BRANCH_EN
  logic signed [PCW-1:0] w_offset;
  assign w_offset = signed'(w_lut_rdata);
  assign w_target = r_pc + $unsigned(w_offset);
`else
  assign w_target = w_lut_rdata;
`endif

  assign w_taken = BranchEn && BranchCond;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (Start) w_next_state = RUN;
      RUN:     if (Halt)  w_next_state = HALTED;
      HALTED:  if (!Start) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // PC and counters; Wrapped only tracks sequential increments, not branches.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_pc      <= '0;
      r_cnt     <= '0;
      r_wrapped <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (Start) begin
            r_pc      <= START_PC;
            r_cnt     <= '0;
            r_wrapped <= 1'b0;
          end
        end
        RUN: begin
          r_cnt <= sat_inc(r_cnt);
          if (!Halt) begin
            if (w_taken) begin
              r_pc <= w_target;
            end else begin
              r_pc <= r_pc + 1'b1;
              if (&r_pc) r_wrapped <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign PC       = r_pc;
  assign Busy     = (r_state == RUN);
  assign Done     = (r_state == HALTED);
  assign Wrapped  = r_wrapped;
  assign CycleCnt = r_cnt;

endmodule
